// File: rtl/cpu_run_controller.sv
// Run-control harness for the cpu top: sequences CPU reset, gates execution, counts run cycles and
// ends a run on timeout or halt. Define RUNCTL_PC_HALT_EN to build the PC branch-to-self halt tracker.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 1500,
  parameter int CNT_W        = 16,
  parameter int PC_W         = 64,
  parameter int HALT_STABLE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  localparam int                HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_CYCLES);
  localparam bit                TIMEOUT_EN = (MAX_CYCLES != 0);

  state_t            state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic [CNT_W-1:0]  count_nx;
  logic              timeout_nx, halted_nx;
  logic              halt_hit;

`ifdef RUNCTL_PC_HALT_EN
  localparam int               REP_W    = $clog2(HALT_STABLE);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_STABLE - 2);

  logic [PC_W-1:0]  last_pc;
  logic             last_vld;
  logic [REP_W-1:0] rep_cnt;
  logic             pc_same;
  logic             track_clr;

  // A fresh run must not match against a PC left over from the previous one.
  assign track_clr = (state != RESET_HOLD) && (state_nx == RESET_HOLD);
  assign pc_same   = pc_valid && last_vld && (pc == last_pc);
  assign halt_hit  = (state == RUN) && pc_same && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
      rep_cnt  <= '0;
    end else if (track_clr) begin
      last_pc  <= '0;
      last_vld <= 1'b0;
      rep_cnt  <= '0;
    end else if ((state == RUN) && pc_valid) begin
      last_pc  <= pc;
      last_vld <= 1'b1;
      rep_cnt  <= pc_same ? rep_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{pc_valid, pc};
  assign halt_hit  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    count_nx    = cycle_count;
    timeout_nx  = timeout;
    halted_nx   = halted;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx    = RESET_HOLD;
          hold_cnt_nx = '0;
          count_nx    = '0;
          timeout_nx  = 1'b0;
          halted_nx   = 1'b0;
        end
      end
      RESET_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
          count_nx = CNT_W'(1);
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        // Halt outranks timeout when both land on the same cycle.
        if (halt_hit) begin
          state_nx  = DONE;
          halted_nx = 1'b1;
        end else if (TIMEOUT_EN && (cycle_count == MAX_CNT)) begin
          state_nx   = DONE;
          timeout_nx = 1'b1;
        end else if (cycle_count != '1) begin
          count_nx = cycle_count + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nx    = RESET_HOLD;
          hold_cnt_nx = '0;
          count_nx    = '0;
          timeout_nx  = 1'b0;
          halted_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nx   = IDLE;
      count_nx   = '0;
      timeout_nx = 1'b0;
      halted_nx  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      halted      <= 1'b0;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state       <= state_nx;
      hold_cnt    <= hold_cnt_nx;
      cycle_count <= count_nx;
      timeout     <= timeout_nx;
      halted      <= halted_nx;
      cpu_reset   <= (state_nx == IDLE) || (state_nx == RESET_HOLD);
      cpu_en      <= (state_nx == RUN);
      running     <= (state_nx == RESET_HOLD) || (state_nx == RUN);
      done        <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: three differently parameterised instances driven in lockstep,
// each compared every cycle against a rule-level model plus directed scenario checks.
module tb_cpu_run_controller;

  localparam int N = 3;

`ifdef RUNCTL_PC_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic        clk, reset, start, abort, pc_valid;
  logic [63:0] pc, pc_ctr;

  wire        cpu_reset_o [N];
  wire        cpu_en_o    [N];
  wire        running_o   [N];
  wire        done_o      [N];
  wire        timeout_o   [N];
  wire        halted_o    [N];
  wire [15:0] cc_o        [N];
  wire [3:0]  cc_c;

  assign cc_o[2] = {12'd0, cc_c};

  cpu_run_controller #(.RESET_CYCLES(1), .MAX_CYCLES(10), .CNT_W(16), .PC_W(64), .HALT_STABLE(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset_o[0]), .cpu_en(cpu_en_o[0]), .running(running_o[0]), .done(done_o[0]),
    .timeout(timeout_o[0]), .halted(halted_o[0]), .cycle_count(cc_o[0]));

  cpu_run_controller #(.RESET_CYCLES(3), .MAX_CYCLES(8), .CNT_W(16), .PC_W(64), .HALT_STABLE(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset_o[1]), .cpu_en(cpu_en_o[1]), .running(running_o[1]), .done(done_o[1]),
    .timeout(timeout_o[1]), .halted(halted_o[1]), .cycle_count(cc_o[1]));

  cpu_run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(0), .CNT_W(4), .PC_W(64), .HALT_STABLE(3)) dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset_o[2]), .cpu_en(cpu_en_o[2]), .running(running_o[2]), .done(done_o[2]),
    .timeout(timeout_o[2]), .halted(halted_o[2]), .cycle_count(cc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic int p_rst(input int i);
    case (i) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int p_max(input int i);
    case (i) 0: return 10; 1: return 8; default: return 0; endcase
  endfunction
  function automatic int p_cw(input int i);
    case (i) 0: return 16; 1: return 16; default: return 4; endcase
  endfunction
  function automatic int p_hs(input int i);
    case (i) 0: return 4; 1: return 4; default: return 3; endcase
  endfunction

  // Reference model: run phase, hold cycles spent, run-cycle number, flags, and the history of
  // valid PCs seen in this run (newest first). A halt is HALT_STABLE identical valid PCs in a row.
  typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE} mphase_e;
  mphase_e     ph     [N];
  int          held   [N];
  int          cnt    [N];
  int          nv     [N];
  bit          to_f   [N];
  bit          ha_f   [N];
  logic [63:0] hist   [N][8];

  task automatic clear_run(input int i);
    cnt[i] = 0; to_f[i] = 1'b0; ha_f[i] = 1'b0; nv[i] = 0; held[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = M_IDLE;
      clear_run(i);
    end
  endtask

  task automatic model_step();
    bit halt;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      case (ph[i])
        M_IDLE: if (start && !abort) begin ph[i] = M_HOLD; clear_run(i); end
        M_HOLD: begin
          if (abort) begin ph[i] = M_IDLE; clear_run(i); end
          else begin
            held[i]++;
            if (held[i] == p_rst(i)) begin ph[i] = M_RUN; cnt[i] = 1; end
          end
        end
        M_RUN: begin
          if (abort) begin ph[i] = M_IDLE; clear_run(i); end
          else begin
            if (pc_valid) begin
              for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
              hist[i][0] = pc;
              nv[i]++;
            end
            halt = HALT_ON && pc_valid && (nv[i] >= p_hs(i));
            if (halt)
              for (int k = 1; k < p_hs(i); k++) if (hist[i][k] != hist[i][0]) halt = 1'b0;
            if (halt) begin ph[i] = M_DONE; ha_f[i] = 1'b1; end
            else if ((p_max(i) != 0) && (cnt[i] == p_max(i))) begin ph[i] = M_DONE; to_f[i] = 1'b1; end
            else if (cnt[i] < (1 << p_cw(i)) - 1) cnt[i]++;
          end
        end
        default: begin
          if (abort) begin ph[i] = M_IDLE; clear_run(i); end
          else if (start) begin ph[i] = M_HOLD; clear_run(i); end
        end
      endcase
    end
  endtask

  function automatic logic [63:0] z(input logic b);
    return {63'd0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d.cpu_reset", i), z(cpu_reset_o[i]), z(ph[i] == M_IDLE || ph[i] == M_HOLD));
      check($sformatf("dut%0d.cpu_en", i), z(cpu_en_o[i]), z(ph[i] == M_RUN));
      check($sformatf("dut%0d.running", i), z(running_o[i]), z(ph[i] == M_HOLD || ph[i] == M_RUN));
      check($sformatf("dut%0d.done", i), z(done_o[i]), z(ph[i] == M_DONE));
      check($sformatf("dut%0d.timeout", i), z(timeout_o[i]), z(to_f[i]));
      check($sformatf("dut%0d.halted", i), z(halted_o[i]), z(ha_f[i]));
      check($sformatf("dut%0d.cycle_count", i), {48'd0, cc_o[i]}, 64'(cnt[i]));
    end
  endtask

  task automatic check_reset_state(input string tag, input int i);
    check({tag, ".cpu_reset"}, z(cpu_reset_o[i]), 64'd1);
    check({tag, ".cpu_en"}, z(cpu_en_o[i]), 64'd0);
    check({tag, ".running"}, z(running_o[i]), 64'd0);
    check({tag, ".done"}, z(done_o[i]), 64'd0);
    check({tag, ".timeout"}, z(timeout_o[i]), 64'd0);
    check({tag, ".halted"}, z(halted_o[i]), 64'd0);
    check({tag, ".cycle_count"}, {48'd0, cc_o[i]}, 64'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all();
  endtask

  // pc parks on 0x40 from run cycle 'from' of instance ref_i; gap_a/gap_b mark invalid repeat cycles.
  task automatic run_pattern(input int ref_i, input int from, input int gap_a, input int gap_b, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      if (ph[ref_i] == M_RUN && cnt[ref_i] >= from) begin
        pc       = 64'h40;
        pc_valid = !(cnt[ref_i] == gap_a || cnt[ref_i] == gap_b);
      end else begin
        pc_ctr   = pc_ctr + 64'd4;
        pc       = pc_ctr;
        pc_valid = 1'b1;
      end
      cycle();
    end
    pc_valid = 1'b1;
  endtask

  initial begin
    int n;
    int en_seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pc_valid = 1'b1; pc_ctr = 64'h1000; pc = pc_ctr;
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    compare_all();
    for (int i = 0; i < N; i++) check_reset_state($sformatf("reset%0d", i), i);
    cycle();
    reset = 1'b1;
    cycle();

    // T1: incrementing pc; A runs exactly 10 enabled cycles, C saturates and keeps running.
    pulse_start();
    check("t1.hold_cpu_reset", z(cpu_reset_o[0]), 64'd1);
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      run_pattern(0, 1000, -1, -1, 1);
      if (cpu_en_o[0]) en_seen++;
    end
    check("t1.enabled_cycles", 64'(en_seen), 64'd10);
    check("t1.done", z(done_o[0]), 64'd1);
    check("t1.timeout", z(timeout_o[0]), 64'd1);
    check("t1.count", {48'd0, cc_o[0]}, 64'd10);
    check("t1.b_count", {48'd0, cc_o[1]}, 64'd8);
    check("t1.c_saturated", {48'd0, cc_o[2]}, 64'd15);
    check("t1.c_running", z(running_o[2]), 64'd1);

    // T2: pc parked from run cycle 5.
    pulse_start();
    run_pattern(0, 5, -1, -1, 20);
    check("t2.halted", z(halted_o[0]), z(HALT_ON));
    check("t2.timeout", z(timeout_o[0]), z(!HALT_ON));
    check("t2.count", {48'd0, cc_o[0]}, HALT_ON ? 64'd8 : 64'd10);

    // T3: two invalid repeat cycles delay the halt by two.
    pulse_start();
    run_pattern(0, 5, 6, 7, 20);
    check("t3.halted", z(halted_o[0]), z(HALT_ON));
    check("t3.timeout", z(timeout_o[0]), z(!HALT_ON));
    check("t3.count", {48'd0, cc_o[0]}, 64'd10);

    // T4: on B, halt and timeout coincide at cycle 8.
    pulse_start();
    run_pattern(1, 5, -1, -1, 20);
    check("t4.halted", z(halted_o[1]), z(HALT_ON));
    check("t4.timeout", z(timeout_o[1]), z(!HALT_ON));
    check("t4.count", {48'd0, cc_o[1]}, 64'd8);

    // T5: asynchronous reset at run cycle 3, then a clean re-run.
    pulse_start();
    n = 0;
    while (!(cpu_en_o[0] && cc_o[0] == 16'd3) && n < 30) begin run_pattern(0, 1000, -1, -1, 1); n++; end
    check("t5.reached_cycle3", z(cpu_en_o[0] && cc_o[0] == 16'd3), 64'd1);
    async_reset_pulse();
    check_reset_state("t5.async", 0);
    cycle();
    reset = 1'b1;
    cycle();
    pulse_start();
    n = 0;
    while (!cpu_en_o[0] && n < 30) begin cycle(); n++; end
    check("t5.first_run_count", {48'd0, cc_o[0]}, 64'd1);

    // T6: abort at run cycle 4, rerun from DONE, and abort beating start.
    n = 0;
    while (!(cpu_en_o[0] && cc_o[0] == 16'd4) && n < 30) begin run_pattern(0, 1000, -1, -1, 1); n++; end
    check("t6.reached_cycle4", z(cpu_en_o[0] && cc_o[0] == 16'd4), 64'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check_reset_state("t6.abort", 0);
    pulse_start();
    n = 0;
    while (!done_o[0] && n < 40) begin run_pattern(0, 5, -1, -1, 1); n++; end
    check("t6.done", z(done_o[0]), 64'd1);
    pulse_start();
    check("t6.rerun_timeout", z(timeout_o[0]), 64'd0);
    check("t6.rerun_halted", z(halted_o[0]), 64'd0);
    check("t6.rerun_count", {48'd0, cc_o[0]}, 64'd0);
    check("t6.rerun_running", z(running_o[0]), 64'd1);
    n = 0;
    while (!done_o[0] && n < 40) begin run_pattern(0, 1000, -1, -1, 1); n++; end
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    check_reset_state("t6.abort_over_start", 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 23) == 0);
      pc_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0, 1:    pc = 64'h40;
        2:       pc = 64'h44;
        default: pc = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 149) == 0) begin
        cycle();
        async_reset_pulse();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
